button_conditioner: RTL

//   Multi-channel successor to the single-bit press edge detector. Per channel:

---
 rtl/input_cond_pkg.sv | 15 +
 rtl/button_conditioner_if.sv | 15 +
 rtl/input_cond_channel.sv | 116 +++++++++++
 rtl/button_conditioner.sv | 38 +++
 4 files changed

// File: rtl/input_cond_pkg.sv
// Shared types and width helpers for the button conditioner.
//   edge_mode_e : which accepted edges produce a pulse
//   SYNC_STAGES : synchroniser depth per channel
//   cnt_width() : bit width needed to hold 0..max_val
package input_cond_pkg;

  typedef enum logic [1:0] {EDGE_RISE, EDGE_FALL, EDGE_BOTH} edge_mode_e;

  localparam int unsigned SYNC_STAGES = 2;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Channel bundle between raw switches and the event consumers.
//   pressed : raw asynchronous inputs, 1 = pressed
//   level   : debounced level per channel
//   pulse   : one-cycle event pulse per channel
// master drives pressed and observes the outputs; slave is the conditioner.
interface button_conditioner_if #(
  parameter int unsigned N_CH = 4
);
  logic [N_CH-1:0] pressed;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] pulse;

  modport master (output pressed, input level, input pulse);
  modport slave  (input pressed, output level, output pulse);
endinterface

// File: rtl/input_cond_channel.sv
// One conditioner channel: 2-flop synchroniser, stable-count debounce, edge
// pulse generation and optional hold-to-repeat.
//   clk     : system clock
//   reset   : synchronous active-high reset
//   pressed : raw asynchronous input
//   level   : debounced, registered level
//   pulse   : registered one-cycle event pulse
module input_cond_channel
  import input_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter edge_mode_e  EDGE_MODE       = EDGE_RISE,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pressed,
  output logic level,
  output logic pulse
);

  localparam int unsigned CntW  = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RMax  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RcntW = cnt_width(RMax);
  localparam logic [CntW-1:0]  CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RcntW-1:0] RDelay  = RcntW'(REPEAT_DELAY);
  localparam logic [RcntW-1:0] RPeriod = RcntW'(REPEAT_PERIOD);
  // Repeat only makes sense when presses themselves generate pulses.
  localparam bit RepeatOn = (REPEAT_EN != 0) && (EDGE_MODE != EDGE_FALL);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [RcntW-1:0]       rcnt_q, rcnt_d, rcnt_inc, rtarget;
  logic                   rperiod_q, rperiod_d;
  logic                   accept, rise, fall, edge_pulse, tick;

  assign sync = sync_q[SYNC_STAGES-1];

  // Debounce: a change is accepted only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement; any return to the current level restarts.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    accept  = 1'b0;
    if (sync == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      level_d = sync;
      cnt_d   = '0;
      accept  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise = accept & level_d;
  assign fall = accept & ~level_d;

  always_comb begin
    edge_pulse = 1'b0;
    if (EDGE_MODE == EDGE_RISE)      edge_pulse = rise;
    else if (EDGE_MODE == EDGE_FALL) edge_pulse = fall;
    else                             edge_pulse = accept;
  end

  // Repeat: first tick REPEAT_DELAY cycles after the accepted press, then every
  // REPEAT_PERIOD. The counter restarts on each tick, so it stays bounded.
  // A release on the same edge takes precedence, so no tick is raised then.
  assign rtarget  = rperiod_q ? RPeriod : RDelay;
  assign rcnt_inc = rcnt_q + 1'b1;

  always_comb begin
    rcnt_d    = rcnt_q;
    rperiod_d = rperiod_q;
    tick      = 1'b0;
    if (!RepeatOn || accept || !level_q) begin
      rcnt_d    = '0;
      rperiod_d = 1'b0;
    end else if (rcnt_inc == rtarget) begin
      rcnt_d    = '0;
      rperiod_d = 1'b1;
      tick      = 1'b1;
    end else begin
      rcnt_d = rcnt_inc;
    end
  end

  assign pulse_d = edge_pulse | tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      level_q   <= 1'b0;
      pulse_q   <= 1'b0;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      rperiod_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pressed};
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      rperiod_q <= rperiod_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: N_CH independent channels, each
// synchronising, debouncing and pulsing on accepted edges (with optional
// hold-to-repeat).
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : slave side of button_conditioner_if (pressed in; level, pulse out)
module button_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter edge_mode_e  EDGE_MODE       = EDGE_RISE,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  button_conditioner_if.slave  bus
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    input_cond_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .EDGE_MODE       (EDGE_MODE),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .pressed (bus.pressed[i]),
      .level   (bus.level[i]),
      .pulse   (bus.pulse[i])
    );
  end

endmodule
